// File: rtl/phase_pkg.sv
// Shared types for the phase-extraction run sequencer.
package phase_pkg;

  typedef logic signed [31:0] fp_t;

  localparam int FP_FRAC = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_SOP = 3'd2,
    COLLECT  = 3'd3,
    NEXT     = 3'd4,
    DONE     = 3'd5,
    ABORT    = 3'd6
  } ctrl_state_t;

  typedef struct packed {
    fp_t freq;
    fp_t mag;
    fp_t phaseA;
    fp_t phaseB;
  } peak_t;

  // Strict signed comparison: ties keep the incumbent.
  function automatic logic peak_stronger(input peak_t cand, input peak_t best);
    return $signed(cand.mag) > $signed(best.mag);
  endfunction

endpackage

// File: rtl/phase_extract_ctrl_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the TIMEOUT-th one.
module watchdog_timer #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Count enabled cycles, saturating on the expiry value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != LAST)) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign expired = enable && (r_count == LAST);

endmodule

// File: rtl/phase_extract_ctrl.sv
// Run sequencer for the phase-extraction datapath: reset pulses, packet tracking, strongest-peak pick.
// Optional macro PHASE_CTRL_AVG_EN: res_phaseA/res_phaseB become the mean of the per-run-best phases.
module phase_extract_ctrl
  import phase_pkg::*;
#(
  parameter int RUNS         = 4,
  parameter int RESET_CYCLES = 2,
  parameter int TIMEOUT      = 65535
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      fft_error,
  input  logic                      peak_sop,
  input  logic                      peak_eop,
  input  logic                      peak_valid,
  input  logic [31:0]               peak_freq,
  input  logic [31:0]               peak_mag,
  input  logic [31:0]               peak_phaseA,
  input  logic [31:0]               peak_phaseB,
  output logic                      time_reset,
  output logic                      fft_reset,
  output logic                      peak_reset,
  output logic                      busy,
  output logic                      done,
  output logic                      abort,
  output logic [$clog2(RUNS+1)-1:0] run_count,
  output logic [31:0]               res_freq,
  output logic [31:0]               res_mag,
  output logic [31:0]               res_phaseA,
  output logic [31:0]               res_phaseB
);

  localparam int RCW = $clog2(RUNS + 1);
  localparam int LCW = $clog2(RESET_CYCLES + 1);
  localparam logic [RCW-1:0] RUN_LAST  = RCW'(RUNS - 1);
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(RESET_CYCLES - 1);

  ctrl_state_t    r_state;
  ctrl_state_t    w_next_state;
  logic [LCW-1:0] r_load_cnt;
  logic [RCW-1:0] r_run_count;
  peak_t          r_run_best;
  peak_t          r_glob_best;
  peak_t          r_res;
  peak_t          w_cand;
  peak_t          w_merged;
  peak_t          w_result;
  logic           r_dp_reset;
  logic           r_busy;
  logic           r_done;
  logic           r_abort;
  logic           w_in_wait;
  logic           w_expired;
  logic           w_meas_start;
  logic           w_sop_beat;
  logic           w_finish;

  assign w_cand       = '{freq: peak_freq, mag: peak_mag, phaseA: peak_phaseA, phaseB: peak_phaseB};
  assign w_in_wait    = (r_state == WAIT_SOP) || (r_state == COLLECT);
  assign w_meas_start = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ABORT));
  assign w_sop_beat   = (r_state == WAIT_SOP) && peak_valid && peak_sop;
  assign w_merged     = peak_stronger(r_run_best, r_glob_best) ? r_run_best : r_glob_best;
  assign w_finish     = (r_state == NEXT) && (w_next_state == DONE);

  // Any valid beat restarts the watchdog; it only runs while waiting on the datapath.
  watchdog_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (peak_valid || !w_in_wait),
    .enable  (w_in_wait),
    .expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; fft_error outranks everything, a valid beat outranks the watchdog.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE, ABORT: begin
        if (start) w_next_state = LOAD;
        else       w_next_state = r_state;
      end
      LOAD: begin
        if (fft_error)                    w_next_state = ABORT;
        else if (r_load_cnt == LOAD_LAST) w_next_state = WAIT_SOP;
        else                              w_next_state = LOAD;
      end
      WAIT_SOP: begin
        if (fft_error)       w_next_state = ABORT;
        else if (w_sop_beat) w_next_state = peak_eop ? NEXT : COLLECT;
        else if (peak_valid) w_next_state = WAIT_SOP;
        else if (w_expired)  w_next_state = ABORT;
        else                 w_next_state = WAIT_SOP;
      end
      COLLECT: begin
        if (fft_error)                   w_next_state = ABORT;
        else if (peak_valid && peak_eop) w_next_state = NEXT;
        else if (peak_valid)             w_next_state = COLLECT;
        else if (w_expired)              w_next_state = ABORT;
        else                             w_next_state = COLLECT;
      end
      NEXT: begin
        if (fft_error)                    w_next_state = ABORT;
        else if (r_run_count == RUN_LAST) w_next_state = DONE;
        else                              w_next_state = LOAD;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Length of the datapath reset pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_cnt <= '0;
    end else if (r_state == LOAD) begin
      r_load_cnt <= r_load_cnt + LCW'(1);
    end else begin
      r_load_cnt <= '0;
    end
  end

  // Run-best and global-best tracking; the sop beat seeds the run-best.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_best  <= '0;
      r_glob_best <= '0;
      r_run_count <= '0;
    end else if (w_meas_start) begin
      r_run_best  <= '0;
      r_glob_best <= '0;
      r_run_count <= '0;
    end else begin
      if (w_sop_beat) begin
        r_run_best <= w_cand;
      end else if ((r_state == COLLECT) && peak_valid && peak_stronger(w_cand, r_run_best)) begin
        r_run_best <= w_cand;
      end else begin
        r_run_best <= r_run_best;
      end
      if (r_state == NEXT) begin
        r_glob_best <= w_merged;
        r_run_count <= r_run_count + RCW'(1);
      end else begin
        r_glob_best <= r_glob_best;
        r_run_count <= r_run_count;
      end
    end
  end

`ifdef PHASE_CTRL_AVG_EN
  localparam int AVG_SH = $clog2(RUNS);
  localparam int AW     = 32 + AVG_SH;

  if ((1 << AVG_SH) != RUNS) begin : g_runs_not_pow2
    $error("phase_extract_ctrl: RUNS must be a power of two when averaging");
  end

  logic signed [AW-1:0] r_acc_a;
  logic signed [AW-1:0] r_acc_b;
  logic signed [AW-1:0] w_sum_a;
  logic signed [AW-1:0] w_sum_b;
  logic signed [AW-1:0] w_avg_a;
  logic signed [AW-1:0] w_avg_b;

  assign w_sum_a = r_acc_a + AW'($signed(r_run_best.phaseA));
  assign w_sum_b = r_acc_b + AW'($signed(r_run_best.phaseB));
  assign w_avg_a = w_sum_a >>> AVG_SH;
  assign w_avg_b = w_sum_b >>> AVG_SH;

  // Phase accumulators, one addition per completed run.
  always_ff @(posedge clk) begin
    if (reset || w_meas_start) begin
      r_acc_a <= '0;
      r_acc_b <= '0;
    end else if (r_state == NEXT) begin
      r_acc_a <= w_sum_a;
      r_acc_b <= w_sum_b;
    end else begin
      r_acc_a <= r_acc_a;
      r_acc_b <= r_acc_b;
    end
  end

  // Frequency/magnitude from the global best, phases from the averages.
  always_comb begin
    w_result        = w_merged;
    w_result.phaseA = w_avg_a[31:0];
    w_result.phaseB = w_avg_b[31:0];
  end
`else
  assign w_result = w_merged;
`endif

  // Registered outputs, decoded from the upcoming state so pulses line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dp_reset <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
      r_res      <= '0;
    end else begin
      r_dp_reset <= (w_next_state == LOAD) || ((w_next_state == ABORT) && (r_state != ABORT));
      r_busy     <= (w_next_state == LOAD) || (w_next_state == WAIT_SOP) ||
                    (w_next_state == COLLECT) || (w_next_state == NEXT);
      r_done     <= w_finish;
      r_abort    <= (w_next_state == ABORT) && (r_state != ABORT);
      if (w_finish) r_res <= w_result;
      else          r_res <= r_res;
    end
  end

  assign time_reset = r_dp_reset;
  assign fft_reset  = r_dp_reset;
  assign peak_reset = r_dp_reset;
  assign busy       = r_busy;
  assign done       = r_done;
  assign abort      = r_abort;
  assign run_count  = r_run_count;
  assign res_freq   = r_res.freq;
  assign res_mag    = r_res.mag;
  assign res_phaseA = r_res.phaseA;
  assign res_phaseB = r_res.phaseB;

endmodule
